of_unit: RTL and testbench



---
 rtl/of_pkg.sv | 37 +++
 rtl/of_if.sv | 36 +++
 rtl/of_regfile.sv | 36 +++
 rtl/of_unit.sv | 89 ++++++++
 tb/tb_of_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/of_pkg.sv
// rtl/of_pkg.sv - SimpleRISC operand-fetch constants, opcodes and halt state type
package of_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;

    localparam logic [XLEN-1:0] NOP_INST = 32'h6800_0000;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_CMP = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_MOV = 5'b01001;
    localparam logic [4:0] OP_LSL = 5'b01010;
    localparam logic [4:0] OP_LSR = 5'b01011;
    localparam logic [4:0] OP_ASR = 5'b01100;
    localparam logic [4:0] OP_NOP = 5'b01101;
    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ST  = 5'b01111;
    localparam logic [4:0] OP_RET = 5'b10100;
    localparam logic [4:0] OP_HLT = 5'b11111;

    localparam logic [1:0] MOD_SEXT = 2'b00;
    localparam logic [1:0] MOD_ZEXT = 2'b01;
    localparam logic [1:0] MOD_HIGH = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } halt_state_t;

endpackage

// File: rtl/of_if.sv
// rtl/of_if.sv - IF/RW-side inputs and EX-side outputs of the operand-fetch stage
interface of_if;
    import of_pkg::*;

    logic [XLEN-1:0] inst_in;
    logic [XLEN-1:0] pc_in;
    logic            stall;
    logic            flush;
    logic            wb_en;
    logic [3:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            valid_out;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] pc_out;
    logic [4:0]      opcode;
    logic            is_imm;
    logic [3:0]      rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] branch_target;
    logic            halted;

    modport slave (
        input  inst_in, pc_in, stall, flush, wb_en, wb_addr, wb_data,
        output valid_out, inst_out, pc_out, opcode, is_imm, rd,
               op1, op2, imm, branch_target, halted
    );

    modport master (
        output inst_in, pc_in, stall, flush, wb_en, wb_addr, wb_data,
        input  valid_out, inst_out, pc_out, opcode, is_imm, rd,
               op1, op2, imm, branch_target, halted
    );
endinterface

// File: rtl/of_regfile.sv
// rtl/of_regfile.sv - 16x32 register file, 2R/1W; OF_FORWARD_EN enables write-through bypass
module of_regfile
    import of_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [3:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [3:0]      i_raddr1,
    input  logic [3:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

`ifdef OF_FORWARD_EN
    assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
`else
    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
`endif

endmodule

// File: rtl/of_unit.sv
// rtl/of_unit.sv - SimpleRISC operand-fetch stage: IF/OF latch, decode, regfile, halt FSM
// Optional OF_FORWARD_EN selects regfile write-through bypass.
module of_unit
    import of_pkg::*;
(
    input  logic clk,
    input  logic rst,
    of_if.slave  bus
);

    localparam logic [0:0] ST_RUN  = 1'(RUN);
    localparam logic [0:0] ST_HALT = 1'(HALT);

    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic [0:0]      r_state;

    logic [4:0]      w_opcode;
    logic [3:0]      w_rd;
    logic [3:0]      w_rs1;
    logic [3:0]      w_rs2;
    logic [3:0]      w_raddr1;
    logic [3:0]      w_raddr2;
    logic [1:0]      w_mod;
    logic [XLEN-1:0] w_imm;

    // Flush beats stall; in HALT only a flush may touch the latch and it never clears HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst  <= NOP_INST;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else if (bus.flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if ((r_state == ST_RUN) && !bus.stall) begin
            r_inst  <= bus.inst_in;
            r_pc    <= bus.pc_in;
            r_valid <= 1'b1;
            if (bus.inst_in[31:27] == OP_HLT) begin
                r_state <= ST_HALT;
            end
        end
    end

    assign w_opcode = r_inst[31:27];
    assign w_rd     = r_inst[25:22];
    assign w_rs1    = r_inst[21:18];
    assign w_rs2    = r_inst[17:14];
    assign w_mod    = r_inst[17:16];

    // ret takes its return address from r15; st stores the value held in rd.
    assign w_raddr1 = (w_opcode == OP_RET) ? 4'd15 : w_rs1;
    assign w_raddr2 = (w_opcode == OP_ST)  ? w_rd  : w_rs2;

    always_comb begin
        w_imm = {{16{r_inst[15]}}, r_inst[15:0]};
        case (w_mod)
            MOD_ZEXT: w_imm = {16'b0, r_inst[15:0]};
            MOD_HIGH: w_imm = {r_inst[15:0], 16'b0};
            default:  w_imm = {{16{r_inst[15]}}, r_inst[15:0]};
        endcase
    end

    of_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data),
        .i_raddr1 (w_raddr1),
        .i_raddr2 (w_raddr2),
        .o_rdata1 (bus.op1),
        .o_rdata2 (bus.op2)
    );

    assign bus.valid_out     = r_valid;
    assign bus.inst_out      = r_inst;
    assign bus.pc_out        = r_pc;
    assign bus.opcode        = w_opcode;
    assign bus.is_imm        = r_inst[26];
    assign bus.rd            = w_rd;
    assign bus.imm           = w_imm;
    assign bus.branch_target = r_pc + {{5{r_inst[26]}}, r_inst[26:0]};
    assign bus.halted        = (r_state == ST_HALT);

endmodule

// File: tb/tb_of_unit.sv
// tb/tb_of_unit.sv - directed self-checking bench for of_unit
module tb_of_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    of_if bus_if();

    of_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_if.inst_in = 32'h6800_0000;
        bus_if.pc_in   = 32'h0;
        bus_if.stall   = 1'b0;
        bus_if.flush   = 1'b0;
        bus_if.wb_en   = 1'b0;
        bus_if.wb_addr = 4'h0;
        bus_if.wb_data = 32'h0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        bus_if.stall   = 1'b1;
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = a;
        bus_if.wb_data = d;
        tick();
        bus_if.wb_en   = 1'b0;
        bus_if.stall   = 1'b0;
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        bus_if.inst_in = inst;
        bus_if.pc_in   = pc;
        bus_if.stall   = 1'b0;
        bus_if.flush   = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        #3;
        checks += 5;
        if (bus_if.inst_out !== 32'h6800_0000) begin failures++; $display("FAIL reset_inst got=%h exp=%h", bus_if.inst_out, 32'h6800_0000); end
        if (bus_if.pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus_if.pc_out); end
        if (bus_if.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid_out); end
        if (bus_if.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus_if.halted); end
        if (bus_if.op1 !== 32'h0) begin failures++; $display("FAIL reset_op1 got=%h exp=0", bus_if.op1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load;
        write_reg(4'd1, 32'd7);
        load(32'h0484_0000, 32'd5);
        checks += 6;
        if (bus_if.valid_out !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", bus_if.valid_out); end
        if (bus_if.pc_out !== 32'd5) begin failures++; $display("FAIL load_pc got=%h exp=5", bus_if.pc_out); end
        if (bus_if.rd !== 4'd2) begin failures++; $display("FAIL load_rd got=%h exp=2", bus_if.rd); end
        if (bus_if.op1 !== 32'd7) begin failures++; $display("FAIL load_op1 got=%h exp=7", bus_if.op1); end
        if (bus_if.op2 !== 32'd0) begin failures++; $display("FAIL load_op2 got=%h exp=0", bus_if.op2); end
        if (bus_if.is_imm !== 1'b1 || bus_if.opcode !== 5'b00000) begin
            failures++; $display("FAIL load_fields got=%b/%b exp=1/00000", bus_if.is_imm, bus_if.opcode);
        end
    endtask

    task automatic test_imm;
        logic [31:0] exp_imm [4];
        exp_imm[0] = 32'hFFFF_FFFE;
        exp_imm[1] = 32'h0000_FFFE;
        exp_imm[2] = 32'hFFFE_0000;
        exp_imm[3] = 32'hFFFF_FFFE;
        for (int m = 0; m < 4; m++) begin
            load({5'b01001, 1'b1, 4'd3, 4'd0, 2'(m), 16'hFFFE}, 32'd8);
            checks++;
            if (bus_if.imm !== exp_imm[m]) begin
                failures++; $display("FAIL imm_mod%0d got=%h exp=%h", m, bus_if.imm, exp_imm[m]);
            end
        end
    endtask

    task automatic test_branch;
        load({5'b10010, 27'h7FF_FFFD}, 32'd10);
        checks++;
        if (bus_if.branch_target !== 32'd7) begin failures++; $display("FAIL branch_neg got=%h exp=7", bus_if.branch_target); end
        load({5'b10010, 27'd2}, 32'hFFFF_FFFF);
        checks++;
        if (bus_if.branch_target !== 32'd1) begin failures++; $display("FAIL branch_wrap got=%h exp=1", bus_if.branch_target); end
    endtask

    task automatic test_stall_flush;
        load(32'h0123_4567, 32'd20);
        bus_if.inst_in = 32'h0BAD_0BAD;
        bus_if.pc_in   = 32'd99;
        bus_if.stall   = 1'b1;
        bus_if.flush   = 1'b1;
        tick();
        checks += 3;
        if (bus_if.inst_out !== 32'h6800_0000) begin failures++; $display("FAIL flush_inst got=%h exp=68000000", bus_if.inst_out); end
        if (bus_if.valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus_if.valid_out); end
        if (bus_if.pc_out !== 32'd20) begin failures++; $display("FAIL flush_pc got=%h exp=20", bus_if.pc_out); end
        bus_if.flush = 1'b0;
        load(32'h0246_8ACE, 32'd30);
        bus_if.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus_if.inst_in = 32'h1111_0000 + 32'(c);
            bus_if.pc_in   = 32'd40 + 32'(c);
            tick();
            checks++;
            if (bus_if.inst_out !== 32'h0246_8ACE || bus_if.pc_out !== 32'd30 || bus_if.valid_out !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=02468ace/1e/1", c, bus_if.inst_out, bus_if.pc_out, bus_if.valid_out);
            end
        end
        bus_if.stall = 1'b0;
    endtask

    task automatic test_ret_st;
        write_reg(4'd15, 32'h0000_1234);
        load({5'b10100, 27'd0}, 32'd50);
        checks++;
        if (bus_if.op1 !== 32'h0000_1234) begin failures++; $display("FAIL ret_op1 got=%h exp=00001234", bus_if.op1); end
        load({5'b01111, 1'b1, 4'd1, 4'd0, 18'd0}, 32'd51);
        checks++;
        if (bus_if.op2 !== 32'd7) begin failures++; $display("FAIL st_op2 got=%h exp=7", bus_if.op2); end
    endtask

    task automatic test_forward;
        logic [31:0] exp_same;
`ifdef OF_FORWARD_EN
        exp_same = 32'hDEAD_BEEF;
`else
        exp_same = 32'h0;
`endif
        load({5'b00000, 1'b0, 4'd0, 4'd4, 18'd0}, 32'd60);
        bus_if.stall   = 1'b1;
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = 4'd4;
        bus_if.wb_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus_if.op1 !== exp_same) begin failures++; $display("FAIL fwd_same_cycle got=%h exp=%h", bus_if.op1, exp_same); end
        @(posedge clk);
        #1;
        bus_if.wb_en = 1'b0;
        #1;
        checks++;
        if (bus_if.op1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fwd_after_edge got=%h exp=deadbeef", bus_if.op1); end
        bus_if.stall = 1'b0;
    endtask

    task automatic test_halt_flush;
        bus_if.inst_in = 32'hF800_0000;
        bus_if.pc_in   = 32'd70;
        bus_if.flush   = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        checks += 2;
        if (bus_if.halted !== 1'b0) begin failures++; $display("FAIL halt_flush_halted got=%b exp=0", bus_if.halted); end
        if (bus_if.valid_out !== 1'b0) begin failures++; $display("FAIL halt_flush_valid got=%b exp=0", bus_if.valid_out); end
    endtask

    task automatic test_halt;
        load(32'hF800_0000, 32'd80);
        checks += 2;
        if (bus_if.halted !== 1'b1) begin failures++; $display("FAIL halt_enter got=%b exp=1", bus_if.halted); end
        if (bus_if.inst_out !== 32'hF800_0000 || bus_if.valid_out !== 1'b1 || bus_if.pc_out !== 32'd80) begin
            failures++; $display("FAIL halt_latch got=%h/%b/%h exp=f8000000/1/50", bus_if.inst_out, bus_if.valid_out, bus_if.pc_out);
        end
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = 4'd0;
        bus_if.wb_data = 32'h0000_0055;
        load(32'h0484_0000, 32'd81);
        bus_if.wb_en = 1'b0;
        checks += 2;
        if (bus_if.inst_out !== 32'hF800_0000 || bus_if.pc_out !== 32'd80 || bus_if.halted !== 1'b1) begin
            failures++; $display("FAIL halt_ignore_load got=%h/%h/%b exp=f8000000/50/1", bus_if.inst_out, bus_if.pc_out, bus_if.halted);
        end
        if (bus_if.op1 !== 32'h0000_0055) begin failures++; $display("FAIL halt_wb got=%h exp=00000055", bus_if.op1); end
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        checks++;
        if (bus_if.inst_out !== 32'h6800_0000 || bus_if.valid_out !== 1'b0 || bus_if.halted !== 1'b1) begin
            failures++; $display("FAIL halt_flush_bubble got=%h/%b/%b exp=68000000/0/1", bus_if.inst_out, bus_if.valid_out, bus_if.halted);
        end
        load(32'h0484_0000, 32'd82);
        checks++;
        if (bus_if.valid_out !== 1'b0 || bus_if.halted !== 1'b1) begin
            failures++; $display("FAIL halt_after_flush got=%b/%b exp=0/1", bus_if.valid_out, bus_if.halted);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (bus_if.halted !== 1'b0 || bus_if.valid_out !== 1'b0 || bus_if.inst_out !== 32'h6800_0000 || bus_if.op1 !== 32'h0) begin
            failures++; $display("FAIL halt_reset got=%b/%b/%h/%h exp=0/0/68000000/0", bus_if.halted, bus_if.valid_out, bus_if.inst_out, bus_if.op1);
        end
        @(negedge clk);
        rst = 1'b0;
        load(32'h0484_0000, 32'd90);
        checks++;
        if (bus_if.valid_out !== 1'b1 || bus_if.pc_out !== 32'd90) begin
            failures++; $display("FAIL run_after_reset got=%b/%h exp=1/5a", bus_if.valid_out, bus_if.pc_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        test_reset();
        test_load();
        test_imm();
        test_branch();
        test_stall_flush();
        test_ret_st();
        test_forward();
        test_halt_flush();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
